// File: rtl/nec_bus_initiator.sv
// V30-style multiplexed bus master: runs one T1-T2-T3-(TW)*-T4 cycle per request,
// honouring READY wait states with a bounded timeout.
module nec_bus_initiator #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [18:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic [19:0] ad_out,
  output logic        ad_oe,
  input  logic [19:0] ad_in,
  output logic        astb,
  output logic        rdn,
  output logic        wrn,
  output logic        ion,
  output logic        ubern,
  output logic        bufrn,
  output logic        bufenn,
  input  logic        ready
);

  typedef enum logic [2:0] {S_IDLE, S_BAD, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t      state, state_nx;
  logic [3:0]  div;
  logic [15:0] wcnt;
  logic        tick;
  logic        wr_q, io_q, tmo_q;
  logic [18:0] addr_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q, data_q;
  logic        unused_ad_hi;

  assign unused_ad_hi = ^ad_in[19:16];
  assign tick = (div == 4'(CLK_DIV - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req) state_nx = (req_be == 2'b00) ? S_BAD : S_T1;
      S_BAD:  state_nx = S_IDLE;
      S_T1:   if (tick) state_nx = S_T2;
      S_T2:   if (tick) state_nx = S_T3;
      S_T3:   if (tick) state_nx = ready ? S_T4 : S_TW;
      S_TW:   if (tick && (ready || wcnt == 16'(MAX_WAIT - 1))) state_nx = S_T4;
      S_T4:   if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    astb   = 1'b0;
    ad_oe  = 1'b0;
    ad_out = 20'h0;
    rdn    = 1'b1;
    wrn    = 1'b1;
    ion    = 1'b1;
    ubern  = 1'b1;
    bufrn  = 1'b1;
    bufenn = 1'b1;
    if (state inside {S_T1, S_T2, S_T3, S_TW, S_T4}) begin
      ion   = ~io_q;
      ubern = ~be_q[1];
      bufrn = wr_q;
    end
    case (state)
      S_T1: begin
        astb   = 1'b1;
        ad_oe  = 1'b1;
        ad_out = {addr_q, (be_q == 2'b10)};
      end
      S_T2, S_T3, S_TW: begin
        bufenn = 1'b0;
        if (wr_q) begin
          ad_oe  = 1'b1;
          ad_out = {4'h0, wdata_q};
          wrn    = 1'b0;
        end else begin
          rdn = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      div     <= '0;
      wcnt    <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      ack   <= 1'b0;
      err   <= 1'b0;
      if (state == S_IDLE) div <= '0;
      else                 div <= tick ? 4'd0 : div + 4'd1;
      case (state)
        S_IDLE: if (req) begin
          busy    <= 1'b1;
          wr_q    <= req_write;
          io_q    <= req_io;
          addr_q  <= req_addr;
          be_q    <= req_be;
          wdata_q <= req_wdata;
          tmo_q   <= 1'b0;
        end
        S_BAD: begin
          ack  <= 1'b1;
          err  <= 1'b1;
          busy <= 1'b0;
        end
        S_T3: if (tick) begin
          if (ready) begin
            if (!wr_q) data_q <= ad_in[15:0];
          end else begin
            wcnt <= '0;
          end
        end
        S_TW: if (tick) begin
          if (ready) begin
            if (!wr_q) data_q <= ad_in[15:0];
          end else if (wcnt == 16'(MAX_WAIT - 1)) begin
            tmo_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_T4: if (tick) begin
          ack  <= 1'b1;
          err  <= tmo_q;
          busy <= 1'b0;
          if (!wr_q) rdata <= tmo_q ? 16'hFFFF : data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_bus_initiator.sv
// Bench for nec_bus_initiator: directed bus cycles plus random transactions checked
// against a transaction-level timing/data model.
module tb_nec_bus_initiator;
  localparam int CD = 4;
  localparam int MW = 4;

  logic        clk = 0, reset = 1;
  logic        req = 0, req_write = 0, req_io = 0;
  logic [18:0] req_addr = '0;
  logic [1:0]  req_be = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, ack, err;
  logic [15:0] rdata;
  logic [19:0] ad_out, ad_in = '0;
  logic        ad_oe, astb, rdn, wrn, ion, ubern, bufrn, bufenn;
  logic        ready = 0;

  int n_chk = 0, n_fail = 0;
  logic [15:0] prev_rdata = 16'h0;

  nec_bus_initiator #(.CLK_DIV(CD), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .busy(busy),
    .ack(ack), .err(err), .rdata(rdata), .ad_out(ad_out), .ad_oe(ad_oe),
    .ad_in(ad_in), .astb(astb), .rdn(rdn), .wrn(wrn), .ion(ion), .ubern(ubern),
    .bufrn(bufrn), .bufenn(bufenn), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bus_vec();
    return {astb, ad_oe, rdn, wrn, ion, ubern, bufrn, bufenn};
  endfunction

  // Caller must be at a negedge with the block idle. Responder releases READY on
  // the (w+1)-th READY sample (T3 tick, then each TW tick).
  task automatic do_txn(input bit wr, input bit io, input logic [18:0] addr,
                        input logic [1:0] be, input logic [15:0] wd, input int w,
                        input logic [15:0] resp);
    int astb_n = 0, rd_n = 0, wr_n = 0, wbad = 0, ack_k = -1;
    logic [19:0] t1_ad = '0;
    logic t1_ion = 1, t1_ube = 1, t1_bufr = 1, t1_oe = 0, busy0 = 0, err_a = 0;
    logic [15:0] rd_a = '0;
    logic [7:0]  bus_a = '0;
    logic        busy_a = 1;
    int weff;
    bit tmo;
    req = 1; req_write = wr; req_io = io; req_addr = addr; req_be = be; req_wdata = wd;
    ready = 0;
    @(posedge clk);
    for (int k = 0; k < 400 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin req = 0; busy0 = busy; end
      if (astb) begin
        astb_n++;
        if (astb_n == 1) begin
          t1_ad = ad_out; t1_ion = ion; t1_ube = ubern; t1_bufr = bufrn; t1_oe = ad_oe;
        end
      end
      if (!rdn) rd_n++;
      if (!wrn) begin
        wr_n++;
        if (ad_oe !== 1'b1 || ad_out !== {4'h0, wd}) wbad++;
      end
      if (ack) begin
        ack_k = k; err_a = err; rd_a = rdata; bus_a = bus_vec(); busy_a = busy;
      end else begin
        ready = (k + 1 >= 3 * CD + CD * w);
        ad_in = !rdn ? {4'h0, resp} : 20'($urandom);
      end
    end
    ready = 0;
    chk("busy_at_accept", busy0, 1);
    if (ack_k < 0) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    weff = (w > MW) ? MW : w;
    tmo  = (w > MW);
    if (be == 2'b00) begin
      chk("bad_be_latency", ack_k, 1);
      chk("bad_be_err", err_a, 1);
      chk("bad_be_rdata", rd_a, prev_rdata);
      chk("bad_be_no_bus", astb_n + rd_n + wr_n, 0);
    end else begin
      chk("latency", ack_k, 4 * CD + CD * weff);
      chk("astb_len", astb_n, CD);
      chk("t1_ad", t1_ad, {addr, (be == 2'b10)});
      chk("t1_strobes", {t1_oe, t1_ion, t1_ube, t1_bufr}, {1'b1, ~io, ~be[1], wr});
      chk("strobe_len", wr ? wr_n : rd_n, CD * (2 + weff));
      chk("other_strobe", wr ? rd_n : wr_n, 0);
      chk("wdata_drive", wbad, 0);
      chk("err", err_a, tmo);
      if (!wr) prev_rdata = tmo ? 16'hFFFF : resp;
      chk("rdata", rd_a, prev_rdata);
    end
    chk("idle_bus_at_ack", bus_a, 8'b0011_1111);
    chk("busy_at_ack", busy_a, 0);
  endtask

  initial begin
    int aborted_acks;
    #12;
    @(negedge clk);
    chk("rst_bus", bus_vec(), 8'b0011_1111);
    chk("rst_ad_out", ad_out, 0);
    chk("rst_flags", {busy, ack, err}, 0);
    chk("rst_rdata", rdata, 0);
    reset = 0;
    @(negedge clk);

    do_txn(0, 0, 19'h0_1234, 2'b11, 16'h0000, 0, 16'hBEEF);
    do_txn(1, 1, 19'h0_0040, 2'b10, 16'hA55A, 0, 16'h0000);
    do_txn(0, 0, 19'h5_5555, 2'b01, 16'h0000, 3, 16'h1357);
    do_txn(0, 1, 19'h7_FFFF, 2'b11, 16'h0000, 100, 16'h2468);
    do_txn(0, 0, 19'h0_0001, 2'b00, 16'h0000, 0, 16'h9999);
    do_txn(0, 0, 19'h1_0000, 2'b11, 16'h0000, MW, 16'hCAFE);

    // Abort a read in T2 with reset; strobes must drop without waiting for a clock.
    req = 1; req_write = 0; req_io = 0; req_addr = 19'h2_2222; req_be = 2'b11;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = 0;
    end
    chk("pre_rst_rdn", rdn, 0);
    reset = 1;
    #1;
    chk("rst_abort_bus", {rdn, bufenn, ad_oe, astb}, 4'b1100);
    chk("rst_abort_busy", busy, 0);
    aborted_acks = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (ack) aborted_acks++; end
    reset = 0;
    prev_rdata = 16'h0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ack) aborted_acks++; end
    chk("rst_no_ack", aborted_acks, 0);
    chk("rst_rdata_clear", rdata, 0);
    do_txn(0, 0, 19'h2_2222, 2'b11, 16'h0000, 0, 16'h7E57);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] be;
      be = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      do_txn(1'($urandom), 1'($urandom), 19'($urandom), be, 16'($urandom),
             $urandom_range(0, MW + 2), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nec_bus_initiator.md
Name: nec_bus_initiator

Overview:
- Bus-cycle generator that drives the NEC V30-style multiplexed bus (AD[19:0], ASTB, RDn, WRn, IOn, UBEn, BUFRn, BUFENn) as a CPU would, and honours READY wait states.
- It is the initiator counterpart of cpu_control, which responds to the CPU. It is used as a loopback/simulation master so cpu_control and the DDRAM path can be exercised without a physical CPU.
- It accepts single word/byte memory or IO transactions from a simple request port and returns the read data or completion status.

Parameters:
- CLK_DIV, 4: clk cycles per T-state; legal range 2..16.
- MAX_WAIT, 255: number of TW states allowed before a timeout abort; legal range 1..65535.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- req  in  1  transaction request; sampled only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_io  in  1  1 = IO space, 0 = memory space
- req_addr  in  19  word address; drives AD[19:1]
- req_be  in  2  byte enables; [0] = low byte, [1] = high byte
- req_wdata  in  16  write data
- busy  out  1  high from acceptance until ack
- ack  out  1  one-cycle completion pulse
- err  out  1  qualifies ack: bad request or timeout
- rdata  out  16  read data; valid with ack, held until next ack
- ad_out  out  20  AD drive value
- ad_oe  out  1  AD output enable
- ad_in  in  20  AD sampled value
- astb  out  1  address strobe, active high
- rdn, wrn, ion, ubern, bufrn, bufenn  out  1 each  active-low bus strobes
- ready  in  1  responder READY, high = proceed

Behaviour:
- Reset (async) values:
  - state = IDLE; astb = 0, ad_oe = 0, ad_out = 0.
  - rdn, wrn, ion, ubern, bufrn, bufenn = 1.
  - busy, ack, err = 0; rdata = 0; divider = 0; wait counter = 0.
  - Reset asserted mid-cycle returns all bus strobes to inactive immediately; no ack is issued for the aborted transaction.
- Tick: a divider counts 0..CLK_DIV-1 while not in IDLE. The tick is high when the count equals CLK_DIV-1. The divider is cleared on acceptance. State transitions other than from IDLE happen only on tick.
- Byte lanes:
  - req_be = 11: A0 = 0, ubern = 0.
  - req_be = 01: A0 = 0, ubern = 1.
  - req_be = 10: A0 = 1, ubern = 0.
  - req_be = 00: illegal. The block starts no bus cycle and, on the next clk, pulses ack with err = 1 and leaves rdata unchanged; busy stays high for that one cycle.
- Acceptance: in IDLE with req = 1, the block latches all req_* fields, sets busy, and enters T1 on the next clk. req is ignored while busy.
- States:
  - T1: astb = 1; ad_oe = 1; ad_out = {req_addr, A0}. ubern, ion (= ~req_io) and bufrn (= req_write, i.e. low for reads) become valid and are held until return to IDLE.
  - T2: astb = 0; bufenn = 0.
    - Read: ad_oe = 0, rdn = 0.
    - Write: ad_oe = 1, ad_out = {4'h0, wdata}, wrn = 0.
  - T3: same outputs as T2. On tick, ready is sampled:
    - ready = 1: go to T4; for a read, latch ad_in[15:0] into a data register.
    - ready = 0: go to TW and clear the wait counter.
  - TW: same outputs as T2. On tick:
    - ready = 1: latch data (read) and go to T4.
    - ready = 0 and wait counter = MAX_WAIT-1: go to T4 with the timeout flag set.
    - otherwise: increment the wait counter.
  - T4: rdn = 1, wrn = 1, bufenn = 1, ad_oe = 0. On tick: return to IDLE, pulse ack, clear busy, and deassert ion/ubern/bufrn.
- Completion:
  - err = timeout flag.
  - rdata = latched data for a read; 16'hFFFF on a read timeout; unchanged on a write.
- Latency: with zero waits, ack occurs exactly 4*CLK_DIV clk cycles after the acceptance cycle. Each wait state adds CLK_DIV cycles.
- Back-to-back: the minimum spacing between acceptances is 4*CLK_DIV+1 clk cycles, because the block returns to IDLE with ack and can accept a new request on the following cycle.
- Byte handling: rdata always carries the full 16 bits from ad_in; byte selection is the requester's job.

Test Plan:
- CLK_DIV=4, memory read addr=19'h0_1234, be=11, ready tied 1, responder drives AD=16'hBEEF:
  - ad_out=20'h02468 with astb high for 4 clks; rdn low for 8 clks.
  - ack at cycle 16 after acceptance; rdata=16'hBEEF, err=0.
- IO write addr=19'h00040, be=10, wdata=16'hA55A:
  - T1 ad_out=20'h00081, ion=0, ubern=0, bufrn=1.
  - T2/T3 ad_out=20'h0A55A, ad_oe=1, wrn low 8 clks; ack err=0.
- Read with ready low for 3 ticks from T3 → exactly 3 TW states; ack at cycle 28; correct data latched.
- MAX_WAIT=4, ready held 0 → 4 TW states, then T4; ack with err=1 and rdata=16'hFFFF; strobes idle afterwards.
- req with be=00 → no astb pulse; ack with err=1 one cycle after acceptance; rdata unchanged.
- Reset asserted during T2 of a read → rdn, bufenn, ad_oe go inactive the same cycle with no ack; a new request after reset completes normally.
